// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Turns a stream of received bytes into framed commands:
//   SYNC_BYTE, OP, LEN, LEN payload bytes [, CHK]
// The decoded opcode and length are held on cmd_* until the consumer takes them.
// The payload sits in a small buffer that is read combinationally via pl_raddr.
// Optional feature macro: UART_CMD_CHKSUM_EN adds a trailing checksum byte.
// That byte is the XOR of OP, LEN and every payload byte.
// A mismatching checksum aborts the frame with err_code 2'b10.
module uart_cmd_parser #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  localparam int        ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_op,
  output logic [7:0]        cmd_len,
  input  logic [ADDR_W-1:0] pl_raddr,
  output logic [7:0]        pl_rdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

`ifdef UART_CMD_CHKSUM_EN
  localparam logic [1:0] ERR_CHK = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_PAYLOAD, S_CHK, S_DONE} state_t;
  // The state entered once the last length/payload byte has been taken.
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_PAYLOAD, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            counting;
  logic            err_set;
  logic [1:0]      err_code_next;
  logic [TO_W-1:0] to_count;
  logic [7:0]      index;
  logic [7:0]      buffer [DEPTH];
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]      chk_acc;
`endif

  assign busy      = (state != S_IDLE);
  assign cmd_valid = (state == S_DONE);
  assign in_ready  = (state != S_DONE);
  assign accept    = in_valid && in_ready;
  assign counting  = busy && !cmd_valid;
  assign pl_rdata  = buffer[pl_raddr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode, frame errors and the inter-byte timeout abort
  always_comb begin
    state_next    = state;
    err_set       = 1'b0;
    err_code_next = 2'b00;
    case (state)
      S_IDLE:
        if (accept && in_data == SYNC_BYTE) state_next = S_OP;
      S_OP:
        if (accept) state_next = S_LEN;
      S_LEN:
        if (accept) begin
          if (in_data > MAX_LEN_B) begin
            state_next    = S_IDLE;
            err_set       = 1'b1;
            err_code_next = ERR_LEN;
          end else if (in_data == 8'd0) begin
            state_next = S_TAIL;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      S_PAYLOAD:
        if (accept && index == cmd_len - 8'd1) state_next = S_TAIL;
`ifdef UART_CMD_CHKSUM_EN
      S_CHK:
        if (accept) begin
          if (in_data == chk_acc) begin
            state_next = S_DONE;
          end else begin
            state_next    = S_IDLE;
            err_set       = 1'b1;
            err_code_next = ERR_CHK;
          end
        end
`endif
      S_DONE:
        if (cmd_ready) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
    // A byte landing in the limit cycle wins over the timeout.
    if (counting && !accept && to_count == TO_LAST) begin
      state_next    = S_IDLE;
      err_set       = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end
  end

  // Command fields, payload index, idle counter and the one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op    <= '0;
      cmd_len   <= '0;
      index     <= '0;
      to_count  <= '0;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      err_valid <= err_set;
      if (err_set) err_code <= err_code_next;
      if (accept || !counting) to_count <= '0;
      else                     to_count <= to_count + TO_W'(1);
      if (accept) begin
        case (state)
          S_OP:      cmd_op <= in_data;
          S_LEN:
            if (in_data <= MAX_LEN_B) begin
              cmd_len <= in_data;
              index   <= '0;
            end
          S_PAYLOAD: index <= index + 8'd1;
          default:   ;
        endcase
      end
    end
  end

`ifdef UART_CMD_CHKSUM_EN
  // Running XOR of OP, LEN and payload, compared against the CHK byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_acc <= '0;
    end else if (accept) begin
      case (state)
        S_OP:             chk_acc <= in_data;
        S_LEN, S_PAYLOAD: chk_acc <= chk_acc ^ in_data;
        default:          ;
      endcase
    end
  end
`endif

  // Payload storage; contents are left stale between frames
  always_ff @(posedge clk) begin
    if (accept && state == S_PAYLOAD) buffer[index[ADDR_W-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Drives directed and random frames into uart_cmd_parser.
// Results are checked against a frame-level model of the parsing rules.
// Honours UART_CMD_CHKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int         MAX_LEN        = 16;
  localparam int         TIMEOUT_CYCLES = 64;
  localparam logic [7:0] SYNC           = 8'h55;
  localparam int         ADDR_W         = $clog2(MAX_LEN);
`ifdef UART_CMD_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_op;
  logic [7:0]        cmd_len;
  logic [ADDR_W-1:0] pl_raddr;
  logic [7:0]        pl_rdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_len(cmd_len),
    .pl_raddr(pl_raddr),
    .pl_rdata(pl_rdata),
    .err_valid(err_valid),
    .err_code(err_code),
    .busy(busy)
  );

  // Event monitor: counts error pulses and command presentations
  int   err_events = 0;
  int   cmd_events = 0;
  logic cmd_prev   = 1'b0;
  always @(negedge clk) begin
    if (err_valid === 1'b1) err_events++;
    if (cmd_valid === 1'b1 && cmd_prev !== 1'b1) cmd_events++;
    cmd_prev = cmd_valid;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame-level reference model
  logic [7:0] frame_q[$];
  logic [7:0] pl_src [256];
  logic [7:0] model_buf [MAX_LEN];
  bit         model_written [MAX_LEN];
  bit         exp_cmd;
  bit         exp_err;
  logic [1:0] exp_code;
  logic [7:0] exp_op;
  logic [7:0] exp_len;
  logic [7:0] exp_pl[$];

  function automatic void model_parse();
    logic [7:0] x;
    exp_cmd  = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_pl.delete();
    exp_op  = frame_q[1];
    exp_len = frame_q[2];
    if (int'(exp_len) > MAX_LEN) begin
      exp_err  = 1'b1;
      exp_code = 2'b01;
      return;
    end
    for (int i = 0; i < int'(exp_len); i++) exp_pl.push_back(frame_q[3 + i]);
    x = exp_op ^ exp_len;
    foreach (exp_pl[i]) x = x ^ exp_pl[i];
    if (CHK_EN && frame_q[3 + int'(exp_len)] != x) begin
      exp_err  = 1'b1;
      exp_code = 2'b10;
      return;
    end
    exp_cmd = 1'b1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is taken on the following rising edge
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Builds one frame from op/len/pl_src, predicts it, drives it, checks it
  task automatic run_frame(input logic [7:0] op, input int len, input bit corrupt,
                           input int stall, input int max_gap);
    logic [7:0] chk;
    int e0;
    int c0;
    frame_q.delete();
    frame_q.push_back(SYNC);
    frame_q.push_back(op);
    frame_q.push_back(8'(len));
    if (len <= MAX_LEN) begin
      chk = op ^ 8'(len);
      for (int i = 0; i < len; i++) begin
        frame_q.push_back(pl_src[i]);
        chk = chk ^ pl_src[i];
        model_buf[i]     = pl_src[i];
        model_written[i] = 1'b1;
      end
      if (corrupt) chk = chk ^ 8'h01;
      if (CHK_EN) frame_q.push_back(chk);
    end
    model_parse();
    e0 = err_events;
    c0 = cmd_events;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (i != frame_q.size() - 1) idle_cycles(int'($urandom_range(max_gap, 0)));
    end
    if (exp_cmd) begin
      check_output("cmd_valid_latency", 32'(cmd_valid), 32'(1));
      check_output("in_ready_done", 32'(in_ready), 32'(0));
      check_output("cmd_op", 32'(cmd_op), 32'(exp_op));
      check_output("cmd_len", 32'(cmd_len), 32'(exp_len));
      for (int i = 0; i < int'(exp_len); i++) begin
        pl_raddr = ADDR_W'(i);
        #1;
        check_output($sformatf("pl_rdata[%0d]", i), 32'(pl_rdata), 32'(exp_pl[i]));
      end
      for (int i = int'(exp_len); i < MAX_LEN; i++) begin
        if (model_written[i]) begin
          pl_raddr = ADDR_W'(i);
          #1;
          check_output($sformatf("stale_rdata[%0d]", i), 32'(pl_rdata), 32'(model_buf[i]));
        end
      end
      @(negedge clk);
      for (int s = 0; s < stall; s++) begin
        check_output("stall_cmd_valid", 32'(cmd_valid), 32'(1));
        check_output("stall_in_ready", 32'(in_ready), 32'(0));
        check_output("stall_cmd_op", 32'(cmd_op), 32'(exp_op));
        check_output("stall_cmd_len", 32'(cmd_len), 32'(exp_len));
        @(negedge clk);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check_output("release_cmd_valid", 32'(cmd_valid), 32'(0));
      check_output("release_busy", 32'(busy), 32'(0));
      check_output("release_in_ready", 32'(in_ready), 32'(1));
      #1;
      check_output("cmd_event_count", 32'(cmd_events), 32'(c0 + 1));
      check_output("no_err_event", 32'(err_events), 32'(e0));
    end else begin
      check_output("err_valid", 32'(err_valid), 32'(1));
      check_output("err_code", 32'(err_code), 32'(exp_code));
      check_output("err_busy", 32'(busy), 32'(0));
      check_output("err_no_cmd", 32'(cmd_valid), 32'(0));
      @(negedge clk);
      check_output("err_pulse_width", 32'(err_valid), 32'(0));
      #1;
      check_output("err_event_count", 32'(err_events), 32'(e0 + 1));
      check_output("err_no_cmd_event", 32'(cmd_events), 32'(c0));
    end
    @(negedge clk);
  endtask

  initial begin
    int e0;
    int c0;
    int len;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b0;
    pl_raddr  = '0;
    foreach (model_written[i]) model_written[i] = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    check_output("rst_err_valid", 32'(err_valid), 32'(0));
    check_output("rst_err_code", 32'(err_code), 32'(0));
    check_output("rst_cmd_op", 32'(cmd_op), 32'(0));
    check_output("rst_cmd_len", 32'(cmd_len), 32'(0));
    check_output("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-byte payload: 55 12 02 AA BB
    $display("[TB] basic frame");
    pl_src[0] = 8'hAA;
    pl_src[1] = 8'hBB;
    run_frame(8'h12, 2, 1'b0, 0, 0);

`ifdef UART_CMD_CHKSUM_EN
    // Good checksum 2E, then the same frame with a bad checksum 2F
    $display("[TB] checksum frames");
    pl_src[0] = 8'h0F;
    run_frame(8'h20, 1, 1'b0, 0, 0);
    run_frame(8'h20, 1, 1'b1, 0, 0);
`endif

    // Over-long frame, then a zero-length frame parses normally
    $display("[TB] length error and recovery");
    run_frame(8'h01, 17, 1'b0, 0, 0);
    run_frame(8'h03, 0, 1'b0, 0, 0);

    // Leading garbage is dropped silently
    $display("[TB] garbage before sync");
    e0 = err_events;
    send_byte(8'h00);
    send_byte(8'hFF);
    check_output("garbage_busy", 32'(busy), 32'(0));
    #1;
    check_output("garbage_no_err", 32'(err_events), 32'(e0));
    @(negedge clk);
    run_frame(8'h05, 0, 1'b0, 0, 0);

    // Completed frame held by a stalled consumer for 50 cycles
    $display("[TB] consumer stall");
    pl_src[0] = 8'h11;
    pl_src[1] = 8'h22;
    pl_src[2] = SYNC;
    run_frame(8'h44, 3, 1'b0, 50, 1);

    // Byte arriving in the limit cycle is taken, then a real timeout in PAYLOAD
    $display("[TB] timeout boundary");
    send_byte(SYNC);
    send_byte(8'h07);
    idle_cycles(TIMEOUT_CYCLES - 1);
    check_output("limit_busy", 32'(busy), 32'(1));
    check_output("limit_no_err", 32'(err_valid), 32'(0));
    send_byte(8'h03);
    check_output("late_byte_no_err", 32'(err_valid), 32'(0));
    check_output("late_byte_busy", 32'(busy), 32'(1));
    idle_cycles(TIMEOUT_CYCLES - 1);
    check_output("payload_wait_busy", 32'(busy), 32'(1));
    idle_cycles(1);
    check_output("to_payload_err_valid", 32'(err_valid), 32'(1));
    check_output("to_payload_err_code", 32'(err_code), 32'(3));
    check_output("to_payload_busy", 32'(busy), 32'(0));
    idle_cycles(1);
    check_output("to_payload_pulse", 32'(err_valid), 32'(0));

    // 55 07 followed by the full idle window
    send_byte(SYNC);
    send_byte(8'h07);
    idle_cycles(TIMEOUT_CYCLES);
    check_output("to_len_err_valid", 32'(err_valid), 32'(1));
    check_output("to_len_err_code", 32'(err_code), 32'(3));
    check_output("to_len_busy", 32'(busy), 32'(0));
    check_output("to_len_no_cmd", 32'(cmd_valid), 32'(0));
    idle_cycles(1);

    // Reset in the middle of a payload discards the frame quietly
    $display("[TB] reset mid-payload");
    e0 = err_events;
    c0 = cmd_events;
    send_byte(SYNC);
    send_byte(8'h09);
    send_byte(8'h04);
    send_byte(8'hA5);
    send_byte(8'h5A);
    model_buf[0] = 8'hA5;
    model_buf[1] = 8'h5A;
    model_written[0] = 1'b1;
    model_written[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 32'(0));
    check_output("midrst_cmd_len", 32'(cmd_len), 32'(0));
    check_output("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    #1;
    check_output("midrst_no_err", 32'(err_events), 32'(e0));
    check_output("midrst_no_cmd", 32'(cmd_events), 32'(c0));
    @(negedge clk);
    pl_src[0] = 8'h01;
    run_frame(8'h66, 1, 1'b0, 0, 0);

    // Random frames, including over-long lengths and sync bytes in the payload
    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      len = int'($urandom_range(MAX_LEN + 3, 0));
      for (int i = 0; i < MAX_LEN; i++) pl_src[i] = 8'($urandom);
      if ($urandom_range(1, 0) == 1) pl_src[0] = SYNC;
      run_frame(8'($urandom), len, bit'($urandom_range(1, 0)),
                int'($urandom_range(3, 0)), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte idle cycles before frame abort (>=2).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'h55, frame start marker.
REQ-004 SHALL have port clk  input  1  single clock; one clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_data  input  8  received byte from UART receiver.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  byte accept / back-pressure to receiver.
REQ-009 SHALL have port cmd_valid  output  1  decoded command available.
REQ-010 SHALL have port cmd_ready  input  1  downstream accepts command.
REQ-011 SHALL have port cmd_op  output  8  command opcode.
REQ-012 SHALL have port cmd_len  output  8  payload byte count.
REQ-013 SHALL have port pl_raddr  input  $clog2(MAX_LEN)  payload buffer read address.
REQ-014 SHALL have port pl_rdata  output  8  payload byte at pl_raddr, combinational.
REQ-015 SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-016 SHALL have port err_code  output  2  01 length, 10 checksum, 11 timeout; valid with err_valid.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 Frame format SHALL be: SYNC_BYTE, OP, LEN, LEN payload bytes, [CHK when UART_CMD_CHKSUM_EN].
REQ-019 A byte SHALL be accepted only in a cycle with in_valid && in_ready.
REQ-020 in_ready SHALL be 1 in states IDLE, OP, LEN, PAYLOAD, CHK and 0 in DONE.
REQ-021 States: IDLE, OP, LEN, PAYLOAD, CHK, DONE.
REQ-022 IDLE: accepted byte == SYNC_BYTE -> OP; any other byte discarded silently, stay IDLE.
REQ-023 OP: accepted byte latched into cmd_op -> LEN.
REQ-024 LEN: accepted byte >MAX_LEN -> IDLE, err_code 01 pulsed next cycle; LEN==0 -> CHK (macro on) or DONE (off); else latch cmd_len, index=0 -> PAYLOAD.
REQ-025 PAYLOAD: accepted byte written to buffer[index], index++; after byte cmd_len-1 -> CHK (macro on) or DONE (off).
REQ-026 DONE: cmd_valid=1; cmd_op, cmd_len, buffer contents held stable; on cmd_valid && cmd_ready -> IDLE, cmd_valid=0 next cycle.
REQ-027 cmd_valid SHALL rise the cycle after the final frame byte is accepted (latency 1).
REQ-028 Timeout counter SHALL run in OP, LEN, PAYLOAD, CHK; clear on every accepted byte and on entry to OP.
REQ-029 Counter reaching TIMEOUT_CYCLES-1 with no byte accepted that cycle -> IDLE, err_code 11; byte accepted in the same cycle wins (no timeout).
REQ-030 err_valid SHALL be exactly one cycle per error; no cmd_valid for an errored frame.
REQ-031 SYNC_BYTE received in OP/LEN/PAYLOAD/CHK SHALL be treated as data, not resync.
REQ-032 pl_raddr >= cmd_len SHALL return stale buffer data, no error.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, cmd_valid=0, err_valid=0, err_code=0, cmd_op=0, cmd_len=0, busy=0, timeout counter=0, index=0.
REQ-034 in_ready SHALL be 1 after reset; buffer contents need not be reset.
REQ-035 Reset mid-frame SHALL discard the partial frame without err_valid.

Configuration
REQ-036 Macro UART_CMD_CHKSUM_EN defined: CHK state present; CHK byte SHALL equal XOR of OP, LEN, all payload bytes; match -> DONE, mismatch -> IDLE, err_code 10.
REQ-037 Macro undefined: no CHK state, err_code 10 never produced, frame ends after last payload byte (or LEN when LEN==0).

Verification
REQ-038 Macro off: bytes 55 12 02 AA BB, cmd_ready=1 -> cmd_valid 1 cycle after BB, cmd_op=12, cmd_len=2, pl_rdata[0]=AA, [1]=BB.
REQ-039 Macro on: 55 20 01 0F 2E -> cmd_valid, op 20; same frame with CHK 2F -> err_valid, err_code 10, no cmd_valid.
REQ-040 55 01 11 (MAX_LEN=16) -> err_code 01 pulse, next 55 03 00 [03] parses normally.
REQ-041 55 07 then TIMEOUT_CYCLES idle cycles -> err_code 11, busy=0; byte arriving exactly at the limit cycle is accepted instead.
REQ-042 Completed frame with cmd_ready=0 for 50 cycles -> in_ready=0, cmd outputs stable; cmd_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-043 Leading garbage 00 FF 55 05 00 -> garbage dropped, op 05 len 0 decoded; rst_n pulse mid-payload -> IDLE, no err_valid.
